// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and the two-port ALU arbiter.
//   - ALU control codes (3-bit)
//   - Arbiter state encoding
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// alu: purely combinational ALU.
// Ports:
//   a, b    in  WIDTH   operands
//   ctrl    in  CTRL_W  operation code (see alu_pkg)
//   result  out WIDTH   operation result, wraps modulo 2^WIDTH
//   zero    out 1       result == 0
// Codes not listed in alu_pkg produce 0.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with round-robin
// arbitration and a single operation in flight.
// Ports:
//   clk, reset               clock (rising edge), asynchronous active-high reset
//   reqN_valid/ready         request handshake for port N (ready combinational)
//   reqN_a, reqN_b, reqN_ctrl operands and ALU code for port N
//   rspN_valid/ready         response handshake for port N (valid registered)
//   rspN_result, rspN_zero   registered result and zero flag
//   busy                     an operation is held (state != IDLE)
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic              rsp0_zero,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp1_zero,
    output logic              busy
);

    arb_state_t        state_reg;
    logic              last_grant_reg;
    logic              owner_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [WIDTH-1:0]  result_reg;
    logic              zero_reg;
    logic [1:0]        rsp_valid_reg;

    logic [1:0]        req_valid;
    logic [1:0]        rsp_ready;
    logic [1:0]        grant;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_zero;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // Round-robin: a lone requester wins; on a contest the port that was
    // not granted last time wins. At most one grant bit is ever set.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req_valid[gi] &&
                               (!req_valid[1-gi] || (last_grant_reg != 1'(gi)));
        end
    endgenerate

    // Ready only exists in IDLE; masked during reset so it reads 0 there.
    assign req0_ready = (state_reg == IDLE) && !reset && grant[0];
    assign req1_ready = (state_reg == IDLE) && !reset && grant[1];

    // The ALU only ever sees the latched operands.
    alu #(
        .WIDTH (WIDTH),
        .CTRL_W(CTRL_W)
    ) u_alu (
        .a     (a_reg),
        .b     (b_reg),
        .ctrl  (ctrl_reg),
        .result(alu_result),
        .zero  (alu_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            ctrl_reg       <= '0;
            result_reg     <= '0;
            zero_reg       <= 1'b0;
            rsp_valid_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        a_reg          <= grant[1] ? req1_a    : req0_a;
                        b_reg          <= grant[1] ? req1_b    : req0_b;
                        ctrl_reg       <= grant[1] ? req1_ctrl : req0_ctrl;
                        owner_reg      <= grant[1];
                        last_grant_reg <= grant[1];
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    result_reg               <= alu_result;
                    zero_reg                 <= alu_zero;
                    rsp_valid_reg[owner_reg] <= 1'b1;
                    state_reg                <= RESP;
                end
                RESP: begin
                    // Only the owner's ready can release the response.
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= '0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign rsp0_valid  = rsp_valid_reg[0];
    assign rsp1_valid  = rsp_valid_reg[1];
    assign rsp0_result = result_reg;
    assign rsp1_result = result_reg;
    assign rsp0_zero   = zero_reg;
    assign rsp1_zero   = zero_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed tests for alu_arbiter with a transaction-level
// reference model checked every cycle, plus literal expectations.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
    logic [W-1:0] req0_a, req0_b, rsp0_result;
    logic [2:0]   req0_ctrl;
    logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [W-1:0] req1_a, req1_b, rsp1_result;
    logic [2:0]   req1_ctrl;
    logic         busy;

    int checks = 0;
    int passed = 0;

    alu_arbiter #(.WIDTH(W), .CTRL_W(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference ALU semantics.
    function automatic logic [W-1:0] ref_alu(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: return '0;
        endcase
    endfunction

    // Which port wins: 0, 1, or 2 for none.
    function automatic int ref_winner(input logic v0, input logic v1, input int last);
        if (v0 && v1) return (last == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return 2;
    endfunction

    // Transaction model: one op held from accept until its response is
    // consumed; the response becomes visible one edge after acceptance.
    logic         m_held;
    logic         m_visible;
    int           m_owner;
    int           m_last;
    logic [W-1:0] m_res;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_held    <= 1'b0;
            m_visible <= 1'b0;
            m_owner   <= 0;
            m_last    <= 1;
            m_res     <= '0;
        end else if (!m_held) begin
            case (ref_winner(req0_valid, req1_valid, m_last))
                0: begin
                    m_held <= 1'b1; m_visible <= 1'b0; m_owner <= 0; m_last <= 0;
                    m_res <= ref_alu(req0_ctrl, req0_a, req0_b);
                end
                1: begin
                    m_held <= 1'b1; m_visible <= 1'b0; m_owner <= 1; m_last <= 1;
                    m_res <= ref_alu(req1_ctrl, req1_a, req1_b);
                end
                default: ;
            endcase
        end else if (!m_visible) begin
            m_visible <= 1'b1;
        end else if ((m_owner == 0 && rsp0_ready) || (m_owner == 1 && rsp1_ready)) begin
            m_held    <= 1'b0;
            m_visible <= 1'b0;
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        int  w;
        logic e_r0, e_r1, e_v0, e_v1;
        w    = ref_winner(req0_valid, req1_valid, m_last);
        e_r0 = !reset && !m_held && (w == 0);
        e_r1 = !reset && !m_held && (w == 1);
        e_v0 = m_visible && (m_owner == 0);
        e_v1 = m_visible && (m_owner == 1);
        check("model_req0_ready", 64'(req0_ready), 64'(e_r0));
        check("model_req1_ready", 64'(req1_ready), 64'(e_r1));
        check("model_rsp0_valid", 64'(rsp0_valid), 64'(e_v0));
        check("model_rsp1_valid", 64'(rsp1_valid), 64'(e_v1));
        check("model_busy", 64'(busy), 64'(m_held));
        if (e_v0) begin
            check("model_rsp0_result", 64'(rsp0_result), 64'(m_res));
            check("model_rsp0_zero", 64'(rsp0_zero), 64'(m_res == '0));
        end
        if (e_v1) begin
            check("model_rsp1_result", 64'(rsp1_result), 64'(m_res));
            check("model_rsp1_zero", 64'(rsp1_zero), 64'(m_res == '0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
    endtask

    // One complete operation on port p with hand-computed expectations.
    task automatic do_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] c, input logic [W-1:0] exp_res, input logic exp_zero);
        int n;
        if (p == 0) begin
            req0_a = a; req0_b = b; req0_ctrl = c; req0_valid = 1'b1; rsp0_ready = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_ctrl = c; req1_valid = 1'b1; rsp1_ready = 1'b1;
        end
        #1;
        n = 0;
        while (!((p == 0) ? req0_ready : req1_ready) && n < 20) begin cyc(1); n++; end
        check("op_grant_within_bound", 64'(n < 20), 64'd1);
        cyc(1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        while (!((p == 0) ? rsp0_valid : rsp1_valid) && n < 20) begin cyc(1); n++; end
        check("op_latency_edges_after_accept", 64'(n), 64'd1);
        check("op_result", 64'((p == 0) ? rsp0_result : rsp1_result), 64'(exp_res));
        check("op_zero", 64'((p == 0) ? rsp0_zero : rsp1_zero), 64'(exp_zero));
        cyc(1);
    endtask

    initial begin
        int n, g, seen;
        int exp_g[4];
        exp_g = '{0, 1, 0, 1};

        reset = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0; rsp0_ready = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0; rsp1_ready = 0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rsp0_valid", 64'(rsp0_valid), 64'd0);
        check("reset_rsp1_valid", 64'(rsp1_valid), 64'd0);
        check("reset_rsp0_result", 64'(rsp0_result), 64'd0);
        check("reset_rsp1_zero", 64'(rsp1_zero), 64'd0);
        cyc(2);
        reset = 1'b0;
        cyc(1);

        // Reset mid-EXEC discards the pending add.
        req0_a = 10; req0_b = 5; req0_ctrl = ALU_ADD; req0_valid = 1; rsp0_ready = 1;
        #1;
        check("midreset_accept_ready", 64'(req0_ready), 64'd1);
        cyc(1);
        req0_valid = 0;
        check("midreset_busy_in_exec", 64'(busy), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_rsp0_valid", 64'(rsp0_valid), 64'd0);
        check("midreset_rsp0_result", 64'(rsp0_result), 64'd0);
        cyc(1);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin cyc(1); if (rsp0_valid) seen++; end
        check("midreset_no_rsp_after_release", 64'(seen), 64'd0);

        // Single port add and sub.
        do_op(0, 10, 5, ALU_ADD, 15, 1'b0);
        do_op(0, 10, 5, ALU_SUB, 5, 1'b0);

        // Contention from a fresh reset: grants 0,1,0,1.
        pulse_reset();
        req0_a = 20; req0_b = 20; req0_ctrl = ALU_SUB; req0_valid = 1; rsp0_ready = 1;
        req1_a = 32'hA; req1_b = 32'h5; req1_ctrl = ALU_OR; req1_valid = 1; rsp1_ready = 1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!req0_ready && !req1_ready && n < 20) begin cyc(1); n++; end
            check("contend_grant_within_bound", 64'(n < 20), 64'd1);
            check("contend_single_grant", 64'(req0_ready && req1_ready), 64'd0);
            g = req1_ready ? 1 : 0;
            check("contend_grant_order", 64'(g), 64'(exp_g[k]));
            cyc(1);
            n = 0;
            while (!((g == 0) ? rsp0_valid : rsp1_valid) && n < 20) begin cyc(1); n++; end
            check("contend_other_rsp_quiet", 64'((g == 0) ? rsp1_valid : rsp0_valid), 64'd0);
            check("contend_result", 64'((g == 0) ? rsp0_result : rsp1_result),
                  (g == 0) ? 64'd0 : 64'hF);
            check("contend_zero", 64'((g == 0) ? rsp0_zero : rsp1_zero), (g == 0) ? 64'd1 : 64'd0);
            cyc(1);
            if (k == 3) begin req0_valid = 0; req1_valid = 0; end
        end
        cyc(2);

        // Backpressure on port 1 while port 0 waits.
        req1_a = 5; req1_b = 10; req1_ctrl = ALU_SLT; req1_valid = 1; rsp1_ready = 0;
        #1;
        check("bp_req1_ready", 64'(req1_ready), 64'd1);
        cyc(1);
        req1_valid = 0;
        req0_a = 1; req0_b = 2; req0_ctrl = ALU_ADD; req0_valid = 1; rsp0_ready = 1;
        #1;
        check("bp_req0_blocked_exec", 64'(req0_ready), 64'd0);
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            check("bp_rsp1_valid_held", 64'(rsp1_valid), 64'd1);
            check("bp_rsp1_result_held", 64'(rsp1_result), 64'd1);
            check("bp_req0_blocked_resp", 64'(req0_ready), 64'd0);
            cyc(1);
        end
        rsp1_ready = 1;
        #1;
        check("bp_req0_blocked_until_edge", 64'(req0_ready), 64'd0);
        cyc(1);
        check("bp_req0_ready_after_release", 64'(req0_ready), 64'd1);
        cyc(1);
        req0_valid = 0;
        cyc(1);
        check("bp_rsp0_valid", 64'(rsp0_valid), 64'd1);
        check("bp_rsp0_result", 64'(rsp0_result), 64'd3);
        cyc(1);

        // Signed slt and wraparound.
        do_op(0, 32'hFFFF_FFFF, 1, ALU_SLT, 1, 1'b0);
        do_op(0, 32'hFFFF_FFFF, 1, ALU_ADD, 0, 1'b1);
        do_op(1, 7, 7, ALU_AND, 7, 1'b0);

        // Withdrawn request on port 1 during port 0's response.
        req0_a = 3; req0_b = 5; req0_ctrl = ALU_AND; req0_valid = 1; rsp0_ready = 0;
        #1;
        cyc(1);
        req0_valid = 0;
        cyc(1);
        check("wd_rsp0_valid", 64'(rsp0_valid), 64'd1);
        check("wd_rsp0_result", 64'(rsp0_result), 64'd1);
        req1_a = 1; req1_b = 1; req1_ctrl = ALU_OR; req1_valid = 1; rsp1_ready = 1;
        #1;
        check("wd_req1_not_ready", 64'(req1_ready), 64'd0);
        seen = 0;
        cyc(1);
        req1_valid = 0;
        if (rsp1_valid) seen++;
        rsp0_ready = 1;
        cyc(1);
        for (int i = 0; i < 5; i++) begin if (rsp1_valid) seen++; cyc(1); end
        check("wd_no_rsp1", 64'(seen), 64'd0);
        check("wd_idle_busy", 64'(busy), 64'd0);

        cyc(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
